fp_mul_normalize: RTL and testbench
===================================

# fp_mul_normalize

Back end of the floating-point multiplier datapath. It consumes the 48-bit significand product together with the leading-zero count produced by the 48-bit leading-zero counter. It normalizes the product, rounds it to nearest-even, and packs an IEEE-754 single-precision result with exception flags. The block is a 3-stage elastic pipeline with valid/ready on both sides and sustains one result per cycle.

## Interface
- No parameters; widths come from `fp_mul_pkg`.
- `i_clk` in 1: clock. Single clock domain.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_valid` in 1: input beat valid.
- `o_ready` out 1: block can accept an input this cycle.
- `i_sign` in 1: result sign (XOR of operand signs).
- `i_exp` in 10: two's-complement biased exponent `ea + eb - 127`. It is valid for a product whose binary point lies between bits 46 and 45.
- `i_mant` in 48: unsigned significand product.
- `i_count` in 6: leading-zero count of `i_mant`, range 0..48. Values above 48 are treated as 48.
- `o_valid` out 1: output beat valid.
- `i_ready` in 1: downstream accepts the output.
- `o_data` out 32: packed single-precision result.
- `o_overflow`, `o_underflow`, `o_inexact` out 1 each: flags qualified by `o_valid`.

## Operation
- **Transfers.** An input transfers when `i_valid & o_ready`. An output transfers when `o_valid & i_ready`.
- **Stage 1 (S1): normalize.**
  - `norm = i_mant << i_count`.
  - `e1 = i_exp + 1 - i_count`, computed 11-bit signed.
  - Zero flag `z = (i_count >= 48)`.
- **Stage 2 (S2): round to nearest-even.**
  - Fraction `f = norm[46:24]`, guard `g = norm[23]`, sticky `s = |norm[22:0]`.
  - Round up when `g & (s | f[0])`.
  - If the increment carries out of `f`: `f = 0`, `e1 = e1 + 1`.
- **Stage 3 (S3): pack, in priority order.**
  1. `z`: output `{sign, 31'b0}`, all flags 0.
  2. `e1 >= 255`: output `{sign, 8'hFF, 23'b0}`, `o_overflow = 1`, `o_inexact = 1`.
  3. `e1 <= 0`: flush to `{sign, 31'b0}`, `o_underflow = 1`, `o_inexact = 1`. Denormals are not produced.
  4. Otherwise: output `{sign, e1[7:0], f}`, `o_inexact = g | s`.
- **Flow control.**
  - Pipeline advance enable: `adv = ~o_valid | i_ready`.
  - All stages shift together when `adv` is high; `o_ready = adv`.
  - Bubbles (valid = 0) propagate. The valid bit of each stage loads from the previous stage on `adv`.
- **Reset.**
  - While `i_rst` is high, all stage valid bits clear immediately. In-flight data is discarded.
  - Reset values: `o_valid = 0`, `o_data = 0`, all flags 0, `o_ready = 1`.

## Timing
- **Latency.** Exactly 3 cycles from input transfer to `o_valid` when `i_ready` is held high.
- **Throughput.** 1 beat per cycle under continuous `i_valid` and `i_ready`.
- **Backpressure.**
  - While `o_valid & ~i_ready`: `o_data` and the flags hold stable, and `o_ready = 0`.
  - No beat is lost or duplicated. At most 3 beats are held.
- **Simultaneous events.** An output transfer and an input transfer can occur in the same cycle; the pipeline shifts by one.
- **Reset mid-stream.** Asserting `i_rst` with `o_valid = 1` drops `o_valid` asynchronously. After release, the first result is the first beat accepted after release.

## Structure
- **Package `fp_mul_pkg`:**
  - Constants `BIAS = 127`, `EXP_MAX = 255`, `MANT_W = 48`, `FRAC_W = 23`.
  - A packed struct for the S1→S2 and S2→S3 stage records: `sign`, `exp` (11-bit), `frac`/`norm`, `g`, `s`, `z`, `valid`.
- **Sub-module `shl_48`:** combinational 6-level logarithmic left shifter, 48-bit data, 6-bit amount, saturating to 0 for amounts ≥ 48.

## Test plan
- **Unity.** `i_mant = 48'h4000_0000_0000`, `i_count = 1`, `i_exp = 127`, `i_sign = 0` → `o_data = 32'h3F80_0000`, flags 0, `o_valid` 3 cycles after acceptance.
- **Tie rounding.**
  - `i_mant = 48'h4000_0040_0000`, `i_count = 1`, `i_exp = 127` → `32'h3F80_0000`, `o_inexact = 1` (tie to even, no increment).
  - `i_mant = 48'h4000_00C0_0000` → `32'h3F80_0002`.
- **Rounding carry.** `i_mant = 48'hFFFF_FFFF_FFFF`, `i_count = 0`, `i_exp = 127` → `32'h4080_0000`, `o_inexact = 1`.
- **Exceptions.**
  - `i_exp = 254`, `i_count = 0`, `i_mant[47] = 1`, `i_sign = 1` → `32'hFF80_0000`, `o_overflow = 1`.
  - `i_exp = 10'h3FB` (−5), `i_count = 1` → `32'h0000_0000`, `o_underflow = 1`.
  - `i_count = 48`, `i_sign = 1` → `32'h8000_0000`, flags 0.
- **Stream with stall and reset.**
  - 8 back-to-back beats with `i_ready` low for cycles 4–6 → results arrive in order with no loss. `o_ready = 0` while the pipeline is full and stalled. Outputs stay stable while stalled.
  - Then pulse `i_rst` mid-stream → `o_valid` falls immediately, and the next accepted beat emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared widths, constants and stage records for the multiplier normalize/round/pack back end.
package fp_mul_pkg;

    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 48;
    localparam int FRAC_W   = 23;
    localparam int EXP_W    = 11;
    localparam int EXP_IN_W = 10;
    localparam int CNT_W    = 6;
    localparam int DATA_W   = 32;

    // S1 -> S2: normalized product without its leading (hidden) bit
    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] norm;
        logic              z;
    } s1_rec_t;

    // S2 -> S3: rounded fraction plus the bits that decide inexactness
    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              g;
        logic              s;
        logic              z;
    } s2_rec_t;

    function automatic logic [DATA_W-1:0] pack_fp(input logic sign, input logic [7:0] e,
                                                  input logic [FRAC_W-1:0] f);
        return {sign, e, f};
    endfunction

endpackage

// File: rtl/fp_mul_normalize_if.sv
// Upstream and downstream valid/ready handshakes of the normalize back end.
interface fp_mul_normalize_if;
    import fp_mul_pkg::*;

    logic                i_valid;
    logic                o_ready;
    logic                i_sign;
    logic [EXP_IN_W-1:0] i_exp;
    logic [MANT_W-1:0]   i_mant;
    logic [CNT_W-1:0]    i_count;
    logic                o_valid;
    logic                i_ready;
    logic [DATA_W-1:0]   o_data;
    logic                o_overflow;
    logic                o_underflow;
    logic                o_inexact;

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_count, i_ready,
        output o_ready, o_valid, o_data, o_overflow, o_underflow, o_inexact
    );

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_count, i_ready,
        input  o_ready, o_valid, o_data, o_overflow, o_underflow, o_inexact
    );

endinterface

// File: rtl/fp_mul_normalize_shl_48.sv
// Six-level logarithmic left shifter; any amount of 48 or more yields zero.
module shl_48
    import fp_mul_pkg::*;
(
    input  logic [MANT_W-1:0] data,
    input  logic [CNT_W-1:0]  amt,
    output logic [MANT_W-1:0] result
);

    logic [CNT_W:0][MANT_W-1:0] stage;

    assign stage[0] = data;

    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_level
            localparam int SH = 1 << gi;
            assign stage[gi+1] = amt[gi] ? {stage[gi][MANT_W-1-SH:0], {SH{1'b0}}} : stage[gi];
        end
    endgenerate

    assign result = (amt >= CNT_W'(MANT_W)) ? '0 : stage[CNT_W];

endmodule

// File: rtl/fp_mul_normalize.sv
// Normalize, round-to-nearest-even and pack a 48-bit significand product into binary32.
// Three-stage elastic pipeline; every stage advances together whenever the output can move.
module fp_mul_normalize
    import fp_mul_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    fp_mul_normalize_if.slave   bus
);

    localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX);

    s1_rec_t           s1_reg, s1_next;
    s2_rec_t           s2_reg, s2_next;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;
    logic              inx_reg, inx_next;

    logic              adv;
    logic [CNT_W-1:0]  cnt_sat;
    logic [MANT_W-1:0] norm_s0;
    logic              lead_unused;

    assign adv         = ~out_valid_reg | bus.i_ready;
    assign bus.o_ready = adv;
    assign cnt_sat     = (bus.i_count > CNT_W'(MANT_W)) ? CNT_W'(MANT_W) : bus.i_count;

    shl_48 u_shl (
        .data   (bus.i_mant),
        .amt    (cnt_sat),
        .result (norm_s0)
    );

    // The leading one lands on bit 47 and is implied in the packed result
    assign lead_unused = norm_s0[MANT_W-1];

    always_comb begin
        s1_next       = '0;
        s1_next.valid = bus.i_valid;
        s1_next.sign  = bus.i_sign;
        s1_next.exp   = {bus.i_exp[EXP_IN_W-1], bus.i_exp} + EXP_W'(1)
                        - {{(EXP_W-CNT_W){1'b0}}, cnt_sat};
        s1_next.norm  = norm_s0[MANT_W-2:0];
        s1_next.z     = (cnt_sat == CNT_W'(MANT_W));
    end

    logic [FRAC_W-1:0] frac_raw;
    logic [FRAC_W-1:0] frac_rnd;
    logic              guard_bit;
    logic              sticky_bit;
    logic              round_up;
    logic              carry;

    always_comb begin
        frac_raw   = s1_reg.norm[MANT_W-2 -: FRAC_W];
        guard_bit  = s1_reg.norm[MANT_W-2-FRAC_W];
        sticky_bit = |s1_reg.norm[MANT_W-3-FRAC_W:0];
        round_up   = guard_bit & (sticky_bit | frac_raw[0]);
        // An all-ones fraction wraps to zero here, which is exactly the post-carry fraction
        {carry, frac_rnd} = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, round_up};

        s2_next       = '0;
        s2_next.valid = s1_reg.valid;
        s2_next.sign  = s1_reg.sign;
        s2_next.exp   = s1_reg.exp + {{(EXP_W-1){1'b0}}, carry};
        s2_next.frac  = frac_rnd;
        s2_next.g     = guard_bit;
        s2_next.s     = sticky_bit;
        s2_next.z     = s1_reg.z;
    end

    always_comb begin
        out_data_next = pack_fp(s2_reg.sign, s2_reg.exp[7:0], s2_reg.frac);
        ovf_next      = 1'b0;
        unf_next      = 1'b0;
        inx_next      = s2_reg.g | s2_reg.s;
        if (s2_reg.z) begin
            out_data_next = pack_fp(s2_reg.sign, 8'h00, '0);
            inx_next      = 1'b0;
        end else if ($signed(s2_reg.exp) >= EXP_MAX_S) begin
            out_data_next = pack_fp(s2_reg.sign, 8'hFF, '0);
            ovf_next      = 1'b1;
            inx_next      = 1'b1;
        end else if ($signed(s2_reg.exp) <= $signed(EXP_W'(0))) begin
            out_data_next = pack_fp(s2_reg.sign, 8'h00, '0);
            unf_next      = 1'b1;
            inx_next      = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_reg        <= '0;
            s2_reg        <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
            inx_reg       <= 1'b0;
        end else if (adv) begin
            s1_reg        <= s1_next;
            s2_reg        <= s2_next;
            out_valid_reg <= s2_reg.valid;
            out_data_reg  <= out_data_next;
            ovf_reg       <= ovf_next;
            unf_reg       <= unf_next;
            inx_reg       <= inx_next;
        end
    end

    assign bus.o_valid     = out_valid_reg;
    assign bus.o_data      = out_data_reg;
    assign bus.o_overflow  = ovf_reg;
    assign bus.o_underflow = unf_reg;
    assign bus.o_inexact   = inx_reg;

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Table-driven scoreboard bench for fp_mul_normalize: vectors, latency, stall and reset sequences.
module tb_fp_mul_normalize;
    import fp_mul_pkg::*;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic [5:0]  cnt;
        logic [31:0] data;
        logic        ov;
        logic        un;
        logic        inx;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        ov;
        logic        un;
        logic        inx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_normalize_if bus();

    fp_mul_normalize dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    localparam int NVEC = 16;
    vec_t  vecs [NVEC];
    vec_t  cur;
    exp_t  sb_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_out    = 0;
    logic [31:0] held_data;
    bit    was_stalled = 0;

    function automatic vec_t mk(input logic sg, input logic [9:0] ex, input logic [47:0] m,
                                input logic [5:0] c, input logic [31:0] d,
                                input logic ov, input logic un, input logic inx);
        vec_t v;
        v.sign = sg; v.exp = ex; v.mant = m; v.cnt = c;
        v.data = d;  v.ov = ov;  v.un = un;  v.inx = inx;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        if (rst) begin
            was_stalled = 0;
        end else begin
            if (bus.o_valid && !bus.i_ready) begin
                check("o_ready_while_stalled", 32'(bus.o_ready), 32'd0);
                if (was_stalled) check("o_data_held", bus.o_data, held_data);
                held_data   = bus.o_data;
                was_stalled = 1;
            end else begin
                was_stalled = 0;
            end
            if (bus.o_valid && bus.i_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    n_out++;
                    $display("out #%0d: data=%h ovf=%0b unf=%0b inx=%0b (expected %h %0b %0b %0b)",
                             n_out, bus.o_data, bus.o_overflow, bus.o_underflow, bus.o_inexact,
                             e.data, e.ov, e.un, e.inx);
                    check("o_data",      bus.o_data,             e.data);
                    check("o_overflow",  32'(bus.o_overflow),  32'(e.ov));
                    check("o_underflow", 32'(bus.o_underflow), 32'(e.un));
                    check("o_inexact",   32'(bus.o_inexact),   32'(e.inx));
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                exp_t e;
                e.data = cur.data; e.ov = cur.ov; e.un = cur.un; e.inx = cur.inx;
                sb_q.push_back(e);
            end
        end
    end

    task automatic set_inputs(input vec_t v);
        cur         = v;
        bus.i_sign  = v.sign;
        bus.i_exp   = v.exp;
        bus.i_mant  = v.mant;
        bus.i_count = v.cnt;
        bus.i_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat
    task automatic send(input vec_t v);
        int guard;
        guard = 0;
        set_inputs(v);
        @(negedge clk);
        while (!bus.o_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic latency(input vec_t v, input string name);
        int n;
        n = 0;
        set_inputs(v);
        @(negedge clk);
        check({name, "_o_ready"}, 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_valid && n < 10);
        check(name, 32'(n), 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1'b0, 10'(BIAS), 48'h4000_0000_0000, 6'd1,  32'h3F80_0000, 0, 0, 0);
        vecs[1]  = mk(1'b0, 10'd127,   48'h4000_0040_0000, 6'd1,  32'h3F80_0000, 0, 0, 1);
        vecs[2]  = mk(1'b0, 10'd127,   48'h4000_00C0_0000, 6'd1,  32'h3F80_0002, 0, 0, 1);
        vecs[3]  = mk(1'b0, 10'd127,   48'hFFFF_FFFF_FFFF, 6'd0,  32'h4080_0000, 0, 0, 1);
        vecs[4]  = mk(1'b1, 10'd254,   48'h8000_0000_0000, 6'd0,  32'hFF80_0000, 1, 0, 1);
        vecs[5]  = mk(1'b0, 10'h3FB,   48'h4000_0000_0000, 6'd1,  32'h0000_0000, 0, 1, 1);
        vecs[6]  = mk(1'b1, 10'd127,   48'h0000_0000_0000, 6'd48, 32'h8000_0000, 0, 0, 0);
        vecs[7]  = mk(1'b0, 10'd253,   48'h8000_0000_0000, 6'd0,  32'h7F00_0000, 0, 0, 0);
        vecs[8]  = mk(1'b0, 10'd0,     48'h8000_0000_0000, 6'd0,  32'h0080_0000, 0, 0, 0);
        vecs[9]  = mk(1'b0, 10'h3FF,   48'h8000_0000_0000, 6'd0,  32'h0000_0000, 0, 1, 1);
        vecs[10] = mk(1'b0, 10'd253,   48'hFFFF_FFFF_FFFF, 6'd0,  32'h7F80_0000, 1, 0, 1);
        vecs[11] = mk(1'b0, 10'd127,   48'h0000_0000_0000, 6'd63, 32'h0000_0000, 0, 0, 0);
        vecs[12] = mk(1'b0, 10'd127,   48'h0000_0000_0001, 6'd47, 32'h2880_0000, 0, 0, 0);
        vecs[13] = mk(1'b0, 10'd126,   48'h8000_0000_0001, 6'd0,  32'h3F80_0000, 0, 0, 1);
        vecs[14] = mk(1'b0, 10'd126,   48'h8000_00C0_0000, 6'd0,  32'h3F80_0001, 0, 0, 1);
        vecs[15] = mk(1'b1, 10'd127,   48'h0000_8000_0000, 6'd16, 32'hB800_0000, 0, 0, 0);

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_sign  = 1'b0;
        bus.i_exp   = '0;
        bus.i_mant  = '0;
        bus.i_count = '0;
        cur         = vecs[0];
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid",     32'(bus.o_valid),     32'd0);
        check("reset_o_data",      bus.o_data,           32'd0);
        check("reset_o_overflow",  32'(bus.o_overflow),  32'd0);
        check("reset_o_underflow", 32'(bus.o_underflow), 32'd0);
        check("reset_o_inexact",   32'(bus.o_inexact),   32'd0);
        check("reset_o_ready",     32'(bus.o_ready),     32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        latency(vecs[0], "latency_unity");
        drain();

        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        drain();

        // Eight back-to-back beats with the sink stalled for cycles 4..6
        fork
            begin
                for (int k = 0; k < 8; k++) send(vecs[k]);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.i_ready = !(c >= 4 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                bus.i_ready = 1'b1;
            end
        join
        drain();

        // Reset while results are in flight
        for (int k = 0; k < 4; k++) send(vecs[8 + k]);
        check("pre_reset_o_valid", 32'(bus.o_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_o_valid", 32'(bus.o_valid), 32'd0);
        check("async_reset_o_data",  bus.o_data,       32'd0);
        check("async_reset_o_ready", 32'(bus.o_ready), 32'd1);
        sb_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        latency(vecs[14], "latency_after_reset");
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
